// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, EX redirects, data-memory wait
// states with a timeout watchdog, and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memread_ex,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rs_id,
  input  logic             uses_rt_id,
  input  logic             branch_taken_ex,
  input  logic             jmp_ex,
  input  logic             jalr_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic mem_wait_s;
  logic redirect_s;
  logic load_use_s;
  logic stall_ev_s;
  logic flush_ev_s;

  // Hazard detection and event classification in priority order
  always_comb begin
    mem_wait_s = ((state_q == RUN) && dmem_req && !dmem_ready) ||
                 ((state_q == MEMWAIT) && !dmem_ready);
    redirect_s = branch_taken_ex | jmp_ex | jalr_ex;
    load_use_s = memread_ex && (rd_ex != 5'd0) &&
                 ((uses_rs_id && (rs_id == rd_ex)) || (uses_rt_id && (rt_id == rd_ex)));
    stall_ev_s = mem_wait_s || (!redirect_s && load_use_s);
    flush_ev_s = (state_q != ERR) && !mem_wait_s && redirect_s;
  end

  // Pipeline control outputs, combinational from state and inputs
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state_q == ERR || mem_wait_s) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (redirect_s) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use_s) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end
  end

  // Next-state for the wait FSM, watchdog and saturating counters
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          // wait_q counts completed wait cycles; ERR is entered as the count reaches TIMEOUT
          if (TIMEOUT <= 1) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end else begin
            state_d = MEMWAIT;
            wait_d  = {{(TO_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = RUN;
        end
      end
      MEMWAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          wait_d  = {TO_W{1'b0}};
        end else begin
          wait_d = wait_q + {{(TO_W-1){1'b0}}, 1'b1};
          if (wait_d == TO_W'(TIMEOUT)) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end else begin
            state_d = MEMWAIT;
          end
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase

    stall_d = stall_q;
    if (stall_ev_s && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
    flush_d = flush_q;
    if (flush_ev_s && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_d = flush_q;
    end
  end

  // State, watchdog and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= {TO_W{1'b0}};
      mem_err_q <= 1'b0;
      stall_q   <= {CNT_W{1'b0}};
      flush_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: table of single-cycle vectors plus
// hand-written memory-wait, timeout, reset and saturation sequences.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             memread_ex;
  logic [4:0]       rd_ex, rs_id, rt_id;
  logic             uses_rs_id, uses_rt_id;
  logic             branch_taken_ex, jmp_ex, jalr_ex;
  logic             dmem_req, dmem_ready;
  logic             pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .memread_ex(memread_ex), .rd_ex(rd_ex), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
    .branch_taken_ex(branch_taken_ex), .jmp_ex(jmp_ex), .jalr_ex(jalr_ex),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pipe_hold(pipe_hold), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // expected control packed as {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}
  typedef struct {
    logic       mr;
    logic [4:0] rd, rs, rt;
    logic       urs, urt, br, jmp, jalr, req, rdy;
    logic [4:0] exp;
  } vec_t;

  localparam logic [4:0] C_DEF   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_FLUSH = 5'b11110;
  localparam logic [4:0] C_HOLD  = 5'b00001;
  localparam logic [4:0] C_RST   = 5'b00110;

  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [4:0] ctrl();
    return {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    memread_ex = v.mr; rd_ex = v.rd; rs_id = v.rs; rt_id = v.rt;
    uses_rs_id = v.urs; uses_rt_id = v.urt;
    branch_taken_ex = v.br; jmp_ex = v.jmp; jalr_ex = v.jalr;
    dmem_req = v.req; dmem_ready = v.rdy;
  endtask

  task automatic clear_in();
    memread_ex = 1'b0; rd_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    uses_rs_id = 1'b0; uses_rt_id = 1'b0;
    branch_taken_ex = 1'b0; jmp_ex = 1'b0; jalr_ex = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    //          mr    rd     rs     rt     urs   urt   br    jmp   jalr  req   rdy   exp
    tbl[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF};
    tbl[1]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL};
    tbl[2]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF};
    tbl[3]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF};
    tbl[4]  = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL};
    tbl[5]  = '{1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF};
    tbl[6]  = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF};
    tbl[7]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_FLUSH};
    tbl[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH};
    tbl[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_FLUSH};
    tbl[10] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_STALL};
    tbl[11] = '{1'b1, 5'd5, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF};

    // Reset values forced even with a memory wait and redirect pending
    clear_in();
    rst = 1'b1;
    dmem_req = 1'b1;
    jmp_ex = 1'b1;
    #2;
    chk("rst_ctrl", 32'(ctrl()), 32'(C_RST));
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    next();
    clear_in();
    rst = 1'b0;
    #1;

    // Single-cycle vectors, all of which stay in RUN
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl()), 32'(tbl[i].exp));
      next();
    end
    clear_in();
    @(negedge clk);
    chk("tbl_stall", 32'(stall_cnt), 32'd3);
    chk("tbl_flush", 32'(flush_cnt), 32'd3);
    chk("tbl_err", 32'(mem_err), 32'd0);

    // Three-cycle memory wait with a jump held in EX, released in cycle 4
    do_reset();
    dmem_req = 1'b1;
    jmp_ex = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("wait%0d_ctrl", c), 32'(ctrl()), 32'(C_HOLD));
      next();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("wait_release_ctrl", 32'(ctrl()), 32'(C_FLUSH));
    next();
    clear_in();
    @(negedge clk);
    chk("wait_after_ctrl", 32'(ctrl()), 32'(C_DEF));
    chk("wait_stall", 32'(stall_cnt), 32'd3);
    chk("wait_flush", 32'(flush_cnt), 32'd1);
    chk("wait_err", 32'(mem_err), 32'd0);

    // Timeout after TIMEOUT wait cycles, sticky ERR, async reset recovery
    do_reset();
    dmem_req = 1'b1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      chk($sformatf("to%0d_ctrl", c), 32'(ctrl()), 32'(C_HOLD));
      chk($sformatf("to%0d_err", c), 32'(mem_err), 32'd0);
      next();
    end
    chk("to_err_set", 32'(mem_err), 32'd1);
    clear_in();
    dmem_ready = 1'b1;
    jmp_ex = 1'b1;
    next();
    next();
    @(negedge clk);
    chk("err_ctrl", 32'(ctrl()), 32'(C_HOLD));
    chk("err_sticky", 32'(mem_err), 32'd1);
    chk("err_stall", 32'(stall_cnt), 32'd4);
    chk("err_flush", 32'(flush_cnt), 32'd0);
    rst = 1'b1;
    #1;
    chk("err_rst_ctrl", 32'(ctrl()), 32'(C_RST));
    chk("err_rst_err", 32'(mem_err), 32'd0);
    chk("err_rst_stall", 32'(stall_cnt), 32'd0);
    next();
    rst = 1'b0;
    clear_in();
    @(negedge clk);
    chk("post_err_ctrl", 32'(ctrl()), 32'(C_DEF));
    chk("post_err_err", 32'(mem_err), 32'd0);

    // Counter saturation at all-ones
    do_reset();
    apply(tbl[1]);
    for (int c = 0; c < 20; c++) next();
    @(negedge clk);
    chk("sat_stall", 32'(stall_cnt), 32'd15);
    chk("sat_stall_flush", 32'(flush_cnt), 32'd0);
    apply(tbl[8]);
    for (int c = 0; c < 20; c++) next();
    @(negedge clk);
    chk("sat_flush", 32'(flush_cnt), 32'd15);
    chk("sat_stall_hold", 32'(stall_cnt), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RV32I core. It generates the `idex_flush` bubble that the ID/EX register consumes, and the PC, IF/ID and freeze controls that go with it. It detects load-use hazards, taken branch/jump redirects resolved in EX, and data-memory wait states, with a timeout watchdog. It also keeps saturating stall and flush event counters for performance analysis. It sits beside the decode stage and drives the write-enable, flush and hold pins of the IF, IF/ID, ID/EX, EX/MEM and MEM/WB stages.

## Interface
- `TIMEOUT`, 255: maximum consecutive memory-wait cycles before `mem_err`.
- `TO_W`, 8: width of the wait counter. Must satisfy 2^TO_W > TIMEOUT.
- `CNT_W`, 32: width of each performance counter.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `memread_ex`  in  1  instruction in EX is a load.
- `rd_ex`  in  5  destination register of the instruction in EX.
- `rs_id`, `rt_id`  in  5 each  source registers of the instruction in ID.
- `uses_rs_id`, `uses_rt_id`  in  1 each  the instruction in ID actually reads rs / rt.
- `branch_taken_ex`, `jmp_ex`, `jalr_ex`  in  1 each  control-flow redirect resolved in EX.
- `dmem_req`  in  1  MEM stage has an access outstanding.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC register update enable.
- `ifid_write`  out  1  IF/ID register update enable.
- `ifid_flush`  out  1  load a NOP into IF/ID.
- `idex_flush`  out  1  zero the ID/EX control fields (bubble).
- `pipe_hold`  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- `mem_err`  out  1  sticky memory-timeout error.
- `stall_cnt`  out  CNT_W  cycles stalled, covering load-use plus memory wait.
- `flush_cnt`  out  CNT_W  number of redirect flush events.

## Operation
- The state machine has three states: `RUN`, `MEMWAIT` and `ERR`. The reset state is `RUN`.
- `RUN` → `MEMWAIT` when `dmem_req & ~dmem_ready`. The wait counter loads 1.
- `MEMWAIT` → `RUN` on `dmem_ready`. Otherwise the wait counter increments.
- `MEMWAIT` → `ERR` when the wait counter equals `TIMEOUT` and `dmem_ready` is low. `mem_err` is set.
- `ERR` is held until `rst`. In `ERR`, outputs are `pipe_hold`=1, `pc_write`=0 and `ifid_write`=0.
- Memory wait is the first priority. Condition: (`RUN` & `dmem_req` & ~`dmem_ready`) or (`MEMWAIT` & ~`dmem_ready`).
  - Outputs: `pipe_hold`=1, `pc_write`=0, `ifid_write`=0, both flushes 0.
- Redirect is the second priority. Condition: `branch_taken_ex | jmp_ex | jalr_ex`.
  - Outputs: `ifid_flush`=1, `idex_flush`=1, `pc_write`=1 (PC loads the target), `ifid_write`=1.
- Load-use is the third priority. Condition: `memread_ex` & (`rd_ex`≠0) & ((`uses_rs_id` & `rs_id`==`rd_ex`) | (`uses_rt_id` & `rt_id`==`rd_ex`)).
  - Outputs: `pc_write`=0, `ifid_write`=0, `idex_flush`=1.
- Otherwise: `pc_write`=1, `ifid_write`=1, all other controls 0.
- A register index of 0 never causes a hazard.
- A redirect that coincides with a memory wait is not lost. It stays in EX because ID/EX is held, and it is taken on the first released cycle.
- `stall_cnt` increments on every load-use cycle and every memory-wait cycle.
- `flush_cnt` increments on every cycle in which a redirect is applied.
- Both counters saturate at all-ones and do not wrap.

## Timing
- All control outputs are combinational from the current state and inputs, with zero-cycle latency.
- The state, wait counter, `mem_err` and both perf counters are registered and update on the rising edge of `clk`.
- While `rst`=1 the outputs are forced:
  - `pc_write`=0, `ifid_write`=0
  - `ifid_flush`=1, `idex_flush`=1
  - `pipe_hold`=0, `mem_err`=0
  - both counters 0
- Reset takes effect immediately, including mid-wait or in `ERR`.
- A load-use hazard costs exactly one bubble cycle. The next cycle's `memread_ex` is 0 because of the flush, so the stall does not repeat.
- A memory wait costs N cycles for a `dmem_ready` arriving N cycles after `dmem_req`. Hold drops in the cycle `dmem_ready`=1 is seen.
- The timeout fires on the edge that ends the TIMEOUT-th consecutive wait cycle without `dmem_ready`.

## Test plan
- Load to x5 in EX; ID reads rs=x5 with `uses_rs_id`=1 → `pc_write`=0, `ifid_write`=0, `idex_flush`=1 for one cycle; `stall_cnt` becomes 1.
- Same as above but `rd_ex`=0, or `uses_rs_id`=0 → no stall; outputs at defaults.
- `branch_taken_ex`=1 together with a load-use match → redirect wins: `ifid_flush`=`idex_flush`=1, `pc_write`=1; `flush_cnt` +1, `stall_cnt` unchanged.
- `dmem_req`=1 with `dmem_ready` low for 3 cycles, `jmp_ex`=1 throughout → `pipe_hold`=1 for 3 cycles and no flush; flush fires in cycle 4; `stall_cnt`=3.
- TIMEOUT=4 and `dmem_ready` never asserted → `mem_err`=1 after the 4th wait cycle and stays set; `rst` pulse clears it and returns outputs to reset values.
- Preload `stall_cnt` near all-ones by forcing or a long run → it saturates at 2^CNT_W−1.
